// File: rtl/spi_slave_wb.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_wb
// Purpose  : SPI mode-0 slave to single-word bus bridge. SCK, SSEL and MOSI
//            are oversampled in the clk_i domain. Each frame carries one
//            command word (we bit + address) followed by data words. A status
//            word is returned during the command word.
// Options  : SPI_SLAVE_WB_BURST_EN - auto-increment burst, unlimited data
//            words per frame. Without it a frame carries one data word.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_wb #(
    parameter int WIDTH = 8,
    parameter int ABITS = 7,
    parameter int SYNC  = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [ABITS-1:0] adr_o,
    output logic [WIDTH-1:0] dat_o,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] status_i,
    output logic             overflow_o,
    output logic             underrun_o,
    output logic             busy_o,
    input  logic             SCK,
    input  logic             SSEL,
    input  logic             MOSI,
    output logic             MISO
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CMD   = 2'd1;
    localparam logic [1:0] S_WDATA = 2'd2;
    localparam logic [1:0] S_RDATA = 2'd3;

`ifdef SPI_SLAVE_WB_BURST_EN
    localparam bit C_BURST = 1'b1;
`else
    localparam bit C_BURST = 1'b0;
`endif

    // Synchronisers and edge-detect history
    logic [SYNC-1:0] sck_sync_q;
    logic [SYNC-1:0] ssel_sync_q;
    logic [SYNC-1:0] mosi_sync_q;
    logic            sck_prev_q;
    logic            ssel_prev_q;

    // FSM
    logic [1:0]      state_q;
    logic [1:0]      state_d;

    // SPI shifters
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH-2:0] rx_q;
    logic [WIDTH-1:0] tx_q;
    logic             miso_q;
    logic             done_q;

    // Bus side
    logic             req_q;
    logic             req_we_q;
    logic [ABITS-1:0] req_adr_q;
    logic [WIDTH-1:0] req_dat_q;
    logic             cyc_q;
    logic             we_q;
    logic [ABITS-1:0] adr_q;
    logic [WIDTH-1:0] dat_q;
    logic [ABITS-1:0] addr_q;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    logic             skip_q;
    logic             overflow_q;
    logic             underrun_q;

    // Decoded FSM outputs
    logic w_active;
    logic w_in_cmd;
    logic w_in_wdata;
    logic w_in_rdata;

    // Synchronised signals and edge events
    logic w_sck;
    logic w_ssel;
    logic w_mosi;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_ssel_rise;
    logic w_ssel_fall;
    logic w_start;
    logic w_stop;

    // Word-level events
    logic [WIDTH-1:0] w_word;
    logic             w_word_done;
    logic             w_cmd_done;
    logic             w_rd_cmd;
    logic             w_data_ok;
    logic             w_bus_busy;
    logic             w_wr_word;
    logic             w_wr_issue;
    logic             w_wr_drop;
    logic             w_load;
    logic             w_rd_live;
    logic             w_ack_rd;
    logic             w_rd_avail;
    logic [WIDTH-1:0] w_rd_word;
    logic             w_rd_hit;
    logic             w_rd_miss;
    logic             w_req_wait;
    logic [WIDTH-1:0] w_tx_word;
    logic             w_addr_inc;
    logic [ABITS-1:0] w_addr_next;

    assign w_sck  = sck_sync_q[SYNC-1];
    assign w_ssel = ssel_sync_q[SYNC-1];
    assign w_mosi = mosi_sync_q[SYNC-1];

    assign w_sck_rise  =  w_sck  & ~sck_prev_q;
    assign w_sck_fall  = ~w_sck  &  sck_prev_q;
    assign w_ssel_rise =  w_ssel & ~ssel_prev_q;
    assign w_ssel_fall = ~w_ssel &  ssel_prev_q;
    assign w_start     = (state_q == S_IDLE) && w_ssel_fall;
    assign w_stop      = w_active && w_ssel_rise;

    // A word completes on the rise that samples its last bit
    assign w_word      = {rx_q, w_mosi};
    assign w_word_done = w_active && w_sck_rise && (bit_cnt_q == C_LAST_BIT);
    assign w_cmd_done  = w_word_done && w_in_cmd;
    assign w_rd_cmd    = w_cmd_done && !w_word[WIDTH-1];

    // Without burst only the first data word of a frame is acted upon
    assign w_data_ok   = C_BURST || !done_q;
    assign w_bus_busy  = (cyc_q && !ack_i) || req_q;
    assign w_wr_word   = w_word_done && w_in_wdata && w_data_ok;
    assign w_wr_issue  = w_wr_word && !w_bus_busy;
    assign w_wr_drop   = w_wr_word && w_bus_busy;

    // The next MISO word is loaded on the fall that follows a word boundary
    assign w_load      = w_active && !w_ssel_rise && w_sck_fall && (bit_cnt_q == '0);
    assign w_rd_live   = w_load && w_in_rdata && w_data_ok;
    assign w_ack_rd    = cyc_q && ack_i && !we_q && !skip_q;
    assign w_rd_avail  = rvalid_q || w_ack_rd;
    assign w_rd_word   = rvalid_q ? rdata_q : dat_i;
    assign w_rd_hit    = w_rd_live && w_rd_avail;
    assign w_rd_miss   = w_rd_live && !w_rd_avail;
    assign w_req_wait  = req_q && cyc_q;
    assign w_tx_word   = w_rd_hit ? w_rd_word : '0;

    assign w_addr_inc  = C_BURST && (w_wr_issue || w_rd_live);
    assign w_addr_next = addr_q + ABITS'(1);

    // Synchronise the SPI pins and keep one cycle of history for edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q  <= '0;
            ssel_sync_q <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ssel_prev_q <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC-2:0], SCK};
            ssel_sync_q <= {ssel_sync_q[SYNC-2:0], SSEL};
            mosi_sync_q <= {mosi_sync_q[SYNC-2:0], MOSI};
            sck_prev_q  <= w_sck;
            ssel_prev_q <= w_ssel;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; SSEL rise always wins, the word itself is still processed
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_ssel_fall) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (w_word_done) begin
                    state_d = w_word[WIDTH-1] ? S_WDATA : S_RDATA;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (w_stop) begin
            state_d = S_IDLE;
        end
    end

    // FSM output decode
    always_comb begin
        w_active   = (state_q != S_IDLE);
        w_in_cmd   = (state_q == S_CMD);
        w_in_wdata = (state_q == S_WDATA);
        w_in_rdata = (state_q == S_RDATA);
        busy_o     = (state_q != S_IDLE) || cyc_q || req_q;
    end

    // SPI shift registers: receive on SCK rise, transmit on SCK fall
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (w_start) begin
            bit_cnt_q <= '0;
            tx_q      <= {status_i[WIDTH-2:0], 1'b0};
            miso_q    <= status_i[WIDTH-1];
            done_q    <= 1'b0;
        end else if (w_stop) begin
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
        end else if (w_active) begin
            if (w_sck_rise) begin
                rx_q      <= w_word[WIDTH-2:0];
                bit_cnt_q <= (bit_cnt_q == C_LAST_BIT) ? '0 : bit_cnt_q + CW'(1);
            end
            if (w_sck_fall) begin
                if (bit_cnt_q == '0) begin
                    tx_q   <= {w_tx_word[WIDTH-2:0], 1'b0};
                    miso_q <= w_tx_word[WIDTH-1];
                end else begin
                    tx_q   <= {tx_q[WIDTH-2:0], 1'b0};
                    miso_q <= tx_q[WIDTH-1];
                end
            end
            if ((w_word_done && w_in_wdata) || (w_load && w_in_rdata)) begin
                done_q <= 1'b1;
            end
        end
    end

    // Bus engine, request queue of one, read return buffer and sticky flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= 1'b0;
            req_we_q   <= 1'b0;
            req_adr_q  <= '0;
            req_dat_q  <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            skip_q     <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (cyc_q) begin
                if (ack_i) begin
                    cyc_q <= 1'b0;
                    we_q  <= 1'b0;
                end
            end else if (req_q) begin
                cyc_q <= 1'b1;
                we_q  <= req_we_q;
                adr_q <= req_adr_q;
                dat_q <= req_dat_q;
                req_q <= 1'b0;
            end

            if (cyc_q && ack_i && !we_q && skip_q) begin
                skip_q <= 1'b0;
            end
            if (w_rd_hit) begin
                rvalid_q <= 1'b0;
            end
            if (w_ack_rd && !(w_rd_hit && !rvalid_q)) begin
                rdata_q  <= dat_i;
                rvalid_q <= 1'b1;
            end

            if (w_start) begin
                overflow_q <= 1'b0;
                underrun_q <= 1'b0;
                rvalid_q   <= 1'b0;
            end

            if (w_cmd_done) begin
                addr_q <= w_word[ABITS-1:0];
            end else if (w_addr_inc) begin
                addr_q <= w_addr_next;
            end

            // A stale read still in flight from an earlier frame is discarded
            if (w_rd_cmd) begin
                rvalid_q  <= 1'b0;
                if (cyc_q && !we_q && !ack_i) begin
                    skip_q <= 1'b1;
                end
                req_q     <= 1'b1;
                req_we_q  <= 1'b0;
                req_adr_q <= w_word[ABITS-1:0];
            end

            if (w_wr_issue) begin
                req_q     <= 1'b1;
                req_we_q  <= 1'b1;
                req_adr_q <= addr_q;
                req_dat_q <= w_word;
            end
            if (w_wr_drop) begin
                overflow_q <= 1'b1;
            end

            if (w_rd_hit && C_BURST) begin
                req_q     <= 1'b1;
                req_we_q  <= 1'b0;
                req_adr_q <= w_addr_next;
            end

            // Late read: send zeros and make sure its data never reaches MISO
            if (w_rd_miss) begin
                underrun_q <= 1'b1;
                if (w_req_wait) begin
                    if (C_BURST) begin
                        req_adr_q <= w_addr_next;
                    end else begin
                        req_q <= 1'b0;
                    end
                end else begin
                    if ((cyc_q && !we_q && !ack_i) || req_q) begin
                        skip_q <= 1'b1;
                    end
                    if (C_BURST) begin
                        req_q     <= 1'b1;
                        req_we_q  <= 1'b0;
                        req_adr_q <= w_addr_next;
                    end
                end
            end
        end
    end

    assign cyc_o      = cyc_q;
    assign stb_o      = cyc_q;
    assign we_o       = we_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
    assign overflow_o = overflow_q;
    assign underrun_o = underrun_q;
    assign MISO       = miso_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_wb
// Purpose  : Directed self-checking bench for spi_slave_wb with an SRAM model
//            whose acknowledge can be stalled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_wb;

    localparam int HALF = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc, stb, we;
    logic       ack = 1'b0;
    logic [6:0] adr;
    logic [7:0] dat_w, dat_r;
    logic [7:0] status = 8'hFC;
    logic       ovf, udr, busy;
    logic       sck = 1'b0, ssel = 1'b1, mosi = 1'b0;
    logic       miso;

    logic [7:0] mem [0:127] = '{default: 8'h00};
    int         stall = 0;
    int         wait_cnt = 0;
    int         wr_count = 0;
    logic [6:0] last_wr_adr = '0;
    logic [7:0] last_wr_dat = '0;

    int         n_chk = 0;
    int         n_pass = 0;
    int         wc;
    logic [7:0] r0, r1, r2;

    always #5 clk = ~clk;

    spi_slave_wb #(.WIDTH(8), .ABITS(7), .SYNC(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cyc_o      (cyc),
        .stb_o      (stb),
        .we_o       (we),
        .adr_o      (adr),
        .dat_o      (dat_w),
        .dat_i      (dat_r),
        .ack_i      (ack),
        .status_i   (status),
        .overflow_o (ovf),
        .underrun_o (udr),
        .busy_o     (busy),
        .SCK        (sck),
        .SSEL       (ssel),
        .MOSI       (mosi),
        .MISO       (miso)
    );

    assign dat_r = mem[adr];

    // SRAM model: acks after 'stall' wait cycles, one-cycle ack pulse
    always @(posedge clk) begin
        ack <= 1'b0;
        if (cyc && stb && !ack) begin
            if (wait_cnt >= stall) begin
                ack      <= 1'b1;
                wait_cnt <= 0;
                if (we) begin
                    mem[adr]    <= dat_w;
                    wr_count    <= wr_count + 1;
                    last_wr_adr <= adr;
                    last_wr_dat <= dat_w;
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic sel_start;
        ssel = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic sel_end;
        repeat (HALF) @(negedge clk);
        ssel = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            rx  = {rx[6:0], miso};
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic frame2(input logic [7:0] a, input logic [7:0] b);
        sel_start();
        xfer(a, 8, r0);
        xfer(b, 8, r1);
        sel_end();
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cyc"},  32'(cyc),   32'd0);
        chk({tag, "_stb"},  32'(stb),   32'd0);
        chk({tag, "_we"},   32'(we),    32'd0);
        chk({tag, "_adr"},  32'(adr),   32'd0);
        chk({tag, "_dat"},  32'(dat_w), 32'd0);
        chk({tag, "_ovf"},  32'(ovf),   32'd0);
        chk({tag, "_udr"},  32'(udr),   32'd0);
        chk({tag, "_busy"}, 32'(busy),  32'd0);
        chk({tag, "_miso"}, 32'(miso),  32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single write to 0x0F, status returned during command
        frame2(8'h8F, 8'h01);
        wait_idle();
        chk("wr_status",   32'(r0),          32'h0000_00FC);
        chk("wr_count",    32'(wr_count),    32'd1);
        chk("wr_adr",      32'(last_wr_adr), 32'h0000_000F);
        chk("wr_dat",      32'(last_wr_dat), 32'h0000_0001);

        // Single read from 0x0F
        frame2(8'h0F, 8'h00);
        wait_idle();
        chk("rd_status",   32'(r0),          32'h0000_00FC);
        chk("rd_data",     32'(r1),          32'h0000_0001);
        chk("rd_no_write", 32'(wr_count),    32'd1);

`ifdef SPI_SLAVE_WB_BURST_EN
        // Burst write wrapping from 0x7F to 0x00
        wc = wr_count;
        sel_start();
        xfer(8'hFE, 8, r0);
        xfer(8'hA1, 8, r1);
        xfer(8'hB2, 8, r1);
        xfer(8'hC3, 8, r2);
        sel_end();
        wait_idle();
        chk("burst_cnt",   32'(wr_count),    32'(wc + 3));
        chk("burst_7e",    32'(mem[7'h7E]),  32'h0000_00A1);
        chk("burst_7f",    32'(mem[7'h7F]),  32'h0000_00B2);
        chk("burst_00",    32'(mem[7'h00]),  32'h0000_00C3);
`else
        // Second data word of a frame is ignored without burst
        wc = wr_count;
        sel_start();
        xfer(8'h85, 8, r0);
        xfer(8'h33, 8, r1);
        xfer(8'h44, 8, r2);
        sel_end();
        wait_idle();
        chk("single_cnt",  32'(wr_count),    32'(wc + 1));
        chk("single_mem",  32'(mem[7'h05]),  32'h0000_0033);
        chk("single_miso", 32'(r2),          32'd0);
        chk("single_adr",  32'(adr),         32'h0000_0005);
`endif

        // Underrun: read ack stalled beyond the word boundary
        stall = 40;
        frame2(8'h0F, 8'h00);
        chk("udr_word",    32'(r1),          32'd0);
        chk("udr_flag",    32'(udr),         32'd1);
        wait_idle();
        stall = 0;
        sel_start();
        chk("udr_clear",   32'(udr),         32'd0);
        xfer(8'h0F, 8, r0);
        xfer(8'h00, 8, r1);
        sel_end();
        chk("udr_recover", 32'(r1),          32'h0000_0001);
        wait_idle();

        // Overflow: second frame's write arrives while the first is unacked
        stall = 300;
        wc = wr_count;
        frame2(8'h81, 8'h11);
        chk("ovf_busy",    32'(busy),        32'd1);
        frame2(8'h82, 8'h22);
        chk("ovf_flag",    32'(ovf),         32'd1);
        wait_idle();
        chk("ovf_cnt",     32'(wr_count),    32'(wc + 1));
        chk("ovf_mem1",    32'(mem[7'h01]),  32'h0000_0011);
        chk("ovf_mem2",    32'(mem[7'h02]),  32'd0);
        stall = 0;
        sel_start();
        chk("ovf_clear",   32'(ovf),         32'd0);
        xfer(8'h01, 8, r0);
        xfer(8'h00, 8, r1);
        sel_end();
        chk("ovf_rd",      32'(r1),          32'h0000_0011);
        wait_idle();

        // Reset mid-frame with an unacked read and underrun set
        stall = 40;
        sel_start();
        xfer(8'h0F, 8, r0);
        xfer(8'h00, 3, r1);
        chk("mid_udr",     32'(udr),         32'd1);
        ssel  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("mid");
        rst_n = 1'b1;
        stall = 0;
        repeat (4) @(negedge clk);
        frame2(8'h0F, 8'h00);
        wait_idle();
        chk("post_status", 32'(r0),          32'h0000_00FC);
        chk("post_data",   32'(r1),          32'h0000_0001);

        // Abort after 5 bits of a write data word
        wc = wr_count;
        sel_start();
        xfer(8'h83, 8, r0);
        xfer(8'h55, 5, r1);
        sel_end();
        wait_idle();
        chk("abort_cnt",   32'(wr_count),    32'(wc));
        chk("abort_mem",   32'(mem[7'h03]),  32'd0);
        frame2(8'h0F, 8'h00);
        wait_idle();
        chk("abort_stat",  32'(r0),          32'h0000_00FC);
        chk("abort_rd",    32'(r1),          32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
